// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// Module   : mmio_timer
// Purpose  : Memory-mapped machine timer responder for the single-cycle core's
//            data-memory bus. 64-bit free-running MTIME, 64-bit MTIMECMP,
//            sticky pending flag and level interrupt. Reads are combinational,
//            writes commit on the rising clock edge.
// Ports    : clk_i     system clock, all state on rising edge
//            rst_ni    asynchronous active-low reset
//            sel_i     timer region selected by the top-level decoder
//            addr_i    byte address, addr_i[4:2] selects the register
//            wdata_i   lane-aligned write data
//            we_i      write strobe, qualified by sel_i
//            be_i      byte enables, be_i[i] gates wdata_i[8i+7:8i]
//            rdata_o   combinational read data, 0 when not selected
//            irq_o     level timer interrupt (PEND & IE)
// Config   : MMIO_TIMER_PRESCALER_EN adds the CTRL.PRESC field and prescaler
//            counter; without it MTIME ticks every cycle while EN=1.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_timer #(
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int unsigned PRESC_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sel_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  localparam logic [2:0] C_OFF_MTIME_LO = 3'd0;
  localparam logic [2:0] C_OFF_MTIME_HI = 3'd1;
  localparam logic [2:0] C_OFF_CMP_LO   = 3'd2;
  localparam logic [2:0] C_OFF_CMP_HI   = 3'd3;
  localparam logic [2:0] C_OFF_CTRL     = 3'd4;
  localparam logic [2:0] C_OFF_STATUS   = 3'd5;

  // Byte-lane merge of a write into an existing 32-bit word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        pend_q, pend_d;
`ifdef MMIO_TIMER_PRESCALER_EN
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
`endif

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic [2:0]  w_off;
  logic        w_wr;
  logic        w_wr_mtime_lo, w_wr_mtime_hi;
  logic        w_wr_cmp_lo, w_wr_cmp_hi;
  logic        w_wr_ctrl;
  logic        w_clr_pend;
  logic        w_tick;
  logic        w_match;
  logic [31:0] w_ctrl_rd;
  logic [31:0] w_ctrl_wr;
  logic        unused_addr;

  assign w_off = addr_i[4:2];
  // A write with no byte enables is treated as no write at all, so it
  // neither touches registers nor suppresses a tick or restarts the prescaler.
  assign w_wr  = sel_i & we_i & (|be_i);

  assign w_wr_mtime_lo = w_wr && (w_off == C_OFF_MTIME_LO);
  assign w_wr_mtime_hi = w_wr && (w_off == C_OFF_MTIME_HI);
  assign w_wr_cmp_lo   = w_wr && (w_off == C_OFF_CMP_LO);
  assign w_wr_cmp_hi   = w_wr && (w_off == C_OFF_CMP_HI);
  assign w_wr_ctrl     = w_wr && (w_off == C_OFF_CTRL);
  assign w_clr_pend    = w_wr && (w_off == C_OFF_STATUS) && be_i[0] && wdata_i[0];

  assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};

  assign w_match = (mtime_q >= mtimecmp_q);

  // CTRL as seen on the bus; also the base for partial-byte CTRL writes.
  always_comb begin
    w_ctrl_rd    = 32'd0;
    w_ctrl_rd[0] = en_q;
    w_ctrl_rd[1] = ie_q;
`ifdef MMIO_TIMER_PRESCALER_EN
    w_ctrl_rd[8 +: PRESC_W] = presc_q;
`endif
  end

  assign w_ctrl_wr = merge_bytes(w_ctrl_rd, wdata_i, be_i);

`ifdef MMIO_TIMER_PRESCALER_EN
  assign w_tick = en_q && (presc_cnt_q == presc_q);
`else
  assign w_tick = en_q;
`endif

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    ie_d       = ie_q;

    if (w_tick) mtime_d = mtime_q + 64'd1;

    // A software write to one MTIME word overrides the tick for the whole
    // counter: the written word takes the merged pre-tick value and the other
    // word holds, so no carry crosses into or out of the written word.
    if (w_wr_mtime_lo) begin
      mtime_d[31:0]  = merge_bytes(mtime_q[31:0], wdata_i, be_i);
      mtime_d[63:32] = mtime_q[63:32];
    end
    if (w_wr_mtime_hi) begin
      mtime_d[63:32] = merge_bytes(mtime_q[63:32], wdata_i, be_i);
      mtime_d[31:0]  = mtime_q[31:0];
    end

    if (w_wr_cmp_lo) mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wdata_i, be_i);
    if (w_wr_cmp_hi) mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wdata_i, be_i);

    if (w_wr_ctrl) begin
      en_d = w_ctrl_wr[0];
      ie_d = w_ctrl_wr[1];
    end

    // Set has priority over a simultaneous clear.
    pend_d = w_match | (pend_q & ~w_clr_pend);
  end

`ifdef MMIO_TIMER_PRESCALER_EN
  always_comb begin
    presc_d     = presc_q;
    presc_cnt_d = presc_cnt_q;
    if (w_wr_ctrl) begin
      presc_d     = w_ctrl_wr[8 +: PRESC_W];
      presc_cnt_d = '0;
    end else if (en_q) begin
      presc_cnt_d = w_tick ? '0 : presc_cnt_q + 1'b1;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= CMP_RESET;
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      ie_q       <= ie_d;
      pend_q     <= pend_d;
    end
  end

`ifdef MMIO_TIMER_PRESCALER_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q     <= '0;
      presc_cnt_q <= '0;
    end else begin
      presc_q     <= presc_d;
      presc_cnt_q <= presc_cnt_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Read path and interrupt
  // --------------------------------------------------------------------------
  always_comb begin
    rdata_o = 32'd0;
    if (sel_i) begin
      case (w_off)
        C_OFF_MTIME_LO: rdata_o = mtime_q[31:0];
        C_OFF_MTIME_HI: rdata_o = mtime_q[63:32];
        C_OFF_CMP_LO:   rdata_o = mtimecmp_q[31:0];
        C_OFF_CMP_HI:   rdata_o = mtimecmp_q[63:32];
        C_OFF_CTRL:     rdata_o = w_ctrl_rd;
        C_OFF_STATUS:   rdata_o = {31'd0, pend_q};
        default:        rdata_o = 32'd0;
      endcase
    end
  end

  assign irq_o = pend_q & ie_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_timer
// Purpose  : Directed self-checking bench for mmio_timer. Expected values are
//            hand-computed; prescaler-dependent values follow
//            MMIO_TIMER_PRESCALER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'd0;
  logic [31:0] rdata;
  logic        irq;

  int n_total = 0;
  int n_pass  = 0;

  mmio_timer dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .sel_i   (sel),
    .addr_i  (addr),
    .wdata_i (wdata),
    .we_i    (we),
    .be_i    (be),
    .rdata_o (rdata),
    .irq_o   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // One bus write: driven in the low phase, committed on the next rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                    input logic s = 1'b1);
    @(negedge clk);
    sel = s; we = 1'b1; addr = a; wdata = d; be = b;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0; be = 4'd0;
  endtask

  // Combinational read; consumes 1 time unit, no clock edge.
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    sel = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] v;

  initial begin
    // ---------------- reset values ----------------
    #23 rst_n = 1'b1;
    #1;
    rd(32'h00, v); check("rst_mtime_lo", v, 32'h0);
    rd(32'h04, v); check("rst_mtime_hi", v, 32'h0);
    rd(32'h08, v); check("rst_cmp_lo",   v, 32'hFFFF_FFFF);
    rd(32'h0C, v); check("rst_cmp_hi",   v, 32'hFFFF_FFFF);
    rd(32'h10, v); check("rst_ctrl",     v, 32'h0);
    rd(32'h14, v); check("rst_status",   v, 32'h0);
    rd(32'h18, v); check("rst_off18",    v, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // ---------------- prescaler / CTRL rewrite ----------------
    wr(32'h10, 32'h0000_0301, 4'hF);
    step(16);
    rd(32'h00, v);
`ifdef MMIO_TIMER_PRESCALER_EN
    check("presc_16cyc", v, 32'd4);
`else
    check("presc_16cyc", v, 32'd16);
`endif
    step(2);
    wr(32'h10, 32'h0000_0301, 4'hF);
    step(3);
    rd(32'h00, v);
`ifdef MMIO_TIMER_PRESCALER_EN
    check("presc_restart", v, 32'd4);
`else
    check("presc_restart", v, 32'd22);
`endif
    step(1);
    rd(32'h00, v);
`ifdef MMIO_TIMER_PRESCALER_EN
    check("presc_restart_tick", v, 32'd5);
`else
    check("presc_restart_tick", v, 32'd23);
`endif

    // ---------------- 64-bit carry and wrap ----------------
    wr(32'h10, 32'h0, 4'hF);
    wr(32'h00, 32'hFFFF_FFFE, 4'hF);
    wr(32'h04, 32'hFFFF_FFFF, 4'hF);
    wr(32'h10, 32'h0000_0001, 4'hF);
    step(2);
    wr(32'h10, 32'h0, 4'hF);          // third ticking edge, then stop
    rd(32'h00, v); check("wrap_lo", v, 32'd1);
    rd(32'h04, v); check("wrap_hi", v, 32'd0);

    // ---------------- compare / PEND / irq ----------------
    wr(32'h00, 32'h0, 4'hF);
    wr(32'h04, 32'h0, 4'hF);
    wr(32'h08, 32'd10, 4'hF);
    wr(32'h0C, 32'h0, 4'hF);
    wr(32'h14, 32'h1, 4'h1);          // clear PEND left by the wrap
    rd(32'h14, v); check("cmp_pend_cleared", v, 32'd0);
    wr(32'h10, 32'h0000_0003, 4'hF);
    step(10);
    rd(32'h00, v); check("cmp_mtime10", v, 32'd10);
    rd(32'h14, v); check("cmp_pend_not_yet", v, 32'd0);
    check("cmp_irq_not_yet", {31'd0, irq}, 32'd0);
    step(1);
    rd(32'h14, v); check("cmp_pend_set", v, 32'd1);
    check("cmp_irq_set", {31'd0, irq}, 32'd1);
    wr(32'h14, 32'h1, 4'hF);
    rd(32'h14, v); check("cmp_set_wins", v, 32'd1);
    check("cmp_irq_held", {31'd0, irq}, 32'd1);
    wr(32'h0C, 32'h1, 4'hF);
    wr(32'h14, 32'h1, 4'hF);
    rd(32'h14, v); check("cmp_pend_clr", v, 32'd0);
    check("cmp_irq_clr", {31'd0, irq}, 32'd0);

    // ---------------- byte enables / sel qualification ----------------
    wr(32'h10, 32'h0, 4'hF);
    wr(32'h00, 32'h1122_3344, 4'hF);
    wr(32'h00, 32'hAA00_0000, 4'b1000);
    rd(32'h00, v); check("byte_write", v, 32'hAA22_3344);
    wr(32'h00, 32'h5500_0000, 4'b1000, 1'b0);
    rd(32'h00, v); check("nosel_write", v, 32'hAA22_3344);
    wr(32'h00, 32'h5555_5555, 4'b0000);
    rd(32'h00, v); check("be0_write", v, 32'hAA22_3344);

    // ---------------- write vs tick collision ----------------
    wr(32'h00, 32'hFFFF_FFFF, 4'hF);
    wr(32'h04, 32'h0000_0005, 4'hF);
    wr(32'h10, 32'h0000_0001, 4'hF);
    wr(32'h00, 32'h0000_0100, 4'hF);  // tick cycle: write wins, no carry
    rd(32'h00, v); check("coll_lo", v, 32'h100);
    rd(32'h04, v); check("coll_hi", v, 32'h5);
    step(1);
    rd(32'h00, v); check("coll_lo_next", v, 32'h101);
    rd(32'h04, v); check("coll_hi_next", v, 32'h5);

    // ---------------- asynchronous reset mid-count ----------------
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rd(32'h00, v); check("arst_mtime_lo", v, 32'h0);
    rd(32'h0C, v); check("arst_cmp_hi", v, 32'hFFFF_FFFF);
    rd(32'h10, v); check("arst_ctrl", v, 32'h0);
    rst_n = 1'b1;
    step(3);
    rd(32'h00, v); check("arst_stays_idle", v, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped machine timer that answers the core's data-memory interface as a responder, alongside data memory, in the single-cycle system. It decodes word reads/writes with byte enables, runs a 64-bit free-running counter with an optional prescaler, compares it against a 64-bit compare register, and raises a level interrupt. Reads are combinational, matching the single-cycle core's same-cycle load expectation. Writes commit on the rising clock edge.

## Interface
- CMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, reset value of MTIMECMP.
- PRESC_W, 8, width of the prescaler field and counter.
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sel  input  1  address decoded into the timer region by the top level; qualifies `we`.
- addr  input  32  byte address; only addr[4:2] is decoded, and addr[1:0] is ignored.
- wdata  input  32  write data, already lane-aligned.
- we  input  1  write strobe, effective only when sel=1.
- be  input  4  byte enables from mem_access_control; be[i] gates wdata[8i+7:8i].
- rdata  output  32  read data, combinational from addr; 0 when sel=0.
- irq  output  1  timer interrupt, level.

## Operation
- Register map (addr[4:2]):
  - 0 MTIME_LO.
  - 1 MTIME_HI.
  - 2 MTIMECMP_LO.
  - 3 MTIMECMP_HI.
  - 4 CTRL: bit0 EN, bit1 IE, bits[8+PRESC_W-1:8] PRESC.
  - 5 STATUS: bit0 PEND, write-1-to-clear.
  - 6–7 read 0, writes ignored.
- Unused CTRL and STATUS bits read 0.
- Write: when sel & we, only bytes with be[i]=1 are updated. be=0 changes nothing.
- Counting: while EN=1, a tick occurs when presc_cnt==PRESC.
  - On a tick, presc_cnt returns to 0 and MTIME increments by 1 as a full 64-bit value with carry from LO to HI.
  - Otherwise presc_cnt increments.
- EN=0: MTIME and presc_cnt hold.
- Wrap: MTIME 64'hFFFF_FFFF_FFFF_FFFF + tick → 0. No flag is raised.
- Any CTRL write resets presc_cnt to 0.
- Software write vs. tick in the same cycle:
  - For the written word, the written bytes take wdata.
  - Unwritten bytes of that word keep their pre-tick value.
  - The other MTIME word is not incremented that cycle, so no carry is propagated.
- Compare: match = (MTIME >= MTIMECMP), 64-bit unsigned, evaluated on current register values.
  - PEND is set on the edge following any cycle with match=1.
  - PEND is sticky.
- STATUS write with be[0]=1 and wdata[0]=1 clears PEND. If match=1 in the same cycle, set wins and PEND stays 1.
- irq = PEND & IE. This is combinational from registers and is glitch-free because both inputs are registered.

## Timing
- Reset values:
  - MTIME=0, MTIMECMP=CMP_RESET, CTRL=0, PEND=0, presc_cnt=0.
  - irq=0.
  - rdata follows addr (e.g. reads CMP words as all-ones).
- Reset assertion mid-count clears everything asynchronously. The first tick after release needs EN to be written to 1.
- Read latency 0 cycles: rdata reflects register state before the current edge.
- Write latency 1 edge: a load from the same address in the next instruction returns the new value.
- Tick period = PRESC+1 cycles. PRESC=0 gives a tick every cycle.
- Match-to-PEND latency 1 cycle; PEND-to-irq 0 cycles.
- Writing MTIMECMP above MTIME does not clear PEND. Software must clear it via STATUS.

## Configuration
- MMIO_TIMER_PRESCALER_EN defined: PRESC field, presc_cnt and the tick rules above are present.
- Undefined:
  - No prescaler logic.
  - A tick occurs every cycle while EN=1.
  - CTRL[31:2] reads 0 and writes to it are ignored.
  - CTRL writes have no counter side effect.

## Test plan
- Reset then read all offsets → MTIME_LO/HI=0, CMP_LO/HI=0xFFFFFFFF, CTRL=0, STATUS=0, offset 0x18=0, irq=0.
- CTRL=0x0000_0301 (EN, PRESC=3), hold 16 cycles → MTIME_LO=4.
  - presc_cnt restarts on a CTRL rewrite.
  - Without the macro, the same write gives MTIME_LO=16.
- MTIME_LO=0xFFFF_FFFE, MTIME_HI=0xFFFF_FFFF, EN, PRESC=0, run 3 cycles → MTIME={HI=0, LO=1}, showing carry and 64-bit wrap.
- MTIMECMP={0,10}, CTRL=0x3 → PEND=1 and irq=1 exactly one cycle after MTIME_LO reaches 10.
  - STATUS write 0x1 with MTIMECMP still ≤ MTIME → PEND remains 1.
  - Set CMP_HI=1, then STATUS write 0x1 → PEND=0 and irq=0.
- Byte write: MTIME_LO=0x1122_3344 with EN=0, then write wdata=0xAA00_0000, be=4'b1000 → MTIME_LO=0xAA22_3344.
  - Same write with sel=0 → no change.
- Write MTIME_LO=0x100 on a tick cycle with EN=1 → MTIME_LO=0x100 next cycle, 0x101 the cycle after, MTIME_HI unchanged.
